cbd_stream: RTL and testbench

Streaming, parametrised centered-binomial-distribution sampler for the Kyber noise path. It accepts PRF output bytes over a valid/ready input stream and selects eta (2 or 3) per polynomial at run time. A bit-level gearbox emits OUT_N coefficients per beat, already reduced mod q = 3329, over a valid/ready output stream. It sits between the SHAKE/PRF block and the NTT input buffer.

---
 rtl/cbd_stream.sv | 196 +++++++++++++++++++
 tb/tb_cbd_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_stream.sv
// -----------------------------------------------------------------------------
// cbd_stream
// Streaming centered-binomial-distribution sampler for the Kyber noise path.
// PRF bytes arrive over a valid/ready input stream, are collected LSB-first in
// a bit buffer, and are turned into OUT_N coefficients per output beat, each
// already reduced mod q = 3329. eta (2 or 3) is chosen per polynomial.
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_eta      : start one polynomial (IDLE only); i_eta==3 -> eta=3
//   i_data/i_valid      : PRF input beat, byte 0 first in the stream
//   o_ready             : input beat accepted when i_valid && o_ready
//   o_coeffs/o_valid    : output beat, coefficient m in [12m+11:12m]
//   i_ready             : output beat consumed when o_valid && i_ready
//   o_last              : with the beat carrying coefficient 255
//   o_busy              : high while a polynomial is in progress
// -----------------------------------------------------------------------------
module cbd_stream #(
    parameter int IN_BYTES = 8,
    parameter int OUT_N    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [1:0]              i_eta,
    input  logic [IN_BYTES*8-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [OUT_N*12-1:0]     o_coeffs,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy
);

    localparam int IW    = IN_BYTES * 8;
    localparam int BW    = 2 * IW;
    localparam int CW    = $clog2(BW + 1);
    localparam int NEED2 = 4 * OUT_N;
    localparam int NEED3 = 6 * OUT_N;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One CBD coefficient from a 2*eta-bit slice (eta=2 uses r[3:0] only).
    // The 3-bit two's complement difference is sign-extended to 12 bits and
    // q is added back for negative values, so the 4096 wrap cancels out.
    function automatic logic [11:0] cbd_coeff(input logic [5:0] r, input logic eta3);
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        if (eta3) begin
            a = {2'b00, r[0]} + {2'b00, r[1]} + {2'b00, r[2]};
            b = {2'b00, r[3]} + {2'b00, r[4]} + {2'b00, r[5]};
        end else begin
            a = {2'b00, r[0]} + {2'b00, r[1]};
            b = {2'b00, r[2]} + {2'b00, r[3]};
        end
        d = a - b;
        return {{9{d[2]}}, d} + (d[2] ? 12'd3329 : 12'd0);
    endfunction

    state_t                 state_q;
    logic                   eta3_q;
    logic [7:0]             bytes_left_q;
    logic [8:0]             coeff_cnt_q;
    logic [BW-1:0]          buf_q;
    logic [CW-1:0]          cnt_q;
    logic                   valid_q;
    logic                   last_q;
    logic [OUT_N*12-1:0]    coeffs_q;

    logic                   run_s;
    logic [CW-1:0]          need_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   drain_s;
    logic                   form_s;
    logic                   last_s;
    logic [BW-1:0]          shifted_s;
    logic [CW-1:0]          cnt_after_s;
    logic [BW-1:0]          buf_d;
    logic [CW-1:0]          cnt_d;
    logic [OUT_N*12-1:0]    coeffs_d;

    // Handshake and beat-formation decisions, all from start-of-cycle state.
    always_comb begin
        run_s    = (state_q == ST_RUN);
        need_s   = eta3_q ? CW'(NEED3) : CW'(NEED2);
        ready_s  = run_s && (bytes_left_q != 8'd0) && (cnt_q <= CW'(IW));
        accept_s = ready_s && i_valid;
        drain_s  = valid_q && i_ready;
        form_s   = run_s && (!valid_q || i_ready) && (cnt_q >= need_s)
                   && (coeff_cnt_q != 9'd256);
        last_s   = (({1'b0, coeff_cnt_q} + 10'(OUT_N)) == 10'd256);
    end

    // Bit buffer next state: shift out the consumed bits first, then append
    // the new beat directly above whatever remains.
    always_comb begin
        shifted_s   = buf_q;
        cnt_after_s = cnt_q;
        if (form_s) begin
            if (eta3_q) begin
                shifted_s = buf_q >> NEED3;
            end else begin
                shifted_s = buf_q >> NEED2;
            end
            cnt_after_s = cnt_q - need_s;
        end else begin
            shifted_s   = buf_q;
            cnt_after_s = cnt_q;
        end
        if (accept_s) begin
            buf_d = shifted_s | ({{IW{1'b0}}, i_data} << cnt_after_s);
            cnt_d = cnt_after_s + CW'(IW);
        end else begin
            buf_d = shifted_s;
            cnt_d = cnt_after_s;
        end
    end

    // Coefficients of the beat that would be formed from the buffer bottom.
    always_comb begin
        coeffs_d = '0;
        for (int m = 0; m < OUT_N; m++) begin
            if (eta3_q) begin
                coeffs_d[12*m +: 12] = cbd_coeff(buf_q[6*m +: 6], 1'b1);
            end else begin
                coeffs_d[12*m +: 12] = cbd_coeff({2'b00, buf_q[4*m +: 4]}, 1'b0);
            end
        end
    end

    // Control FSM, counters, bit buffer and registered output beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            eta3_q       <= 1'b0;
            bytes_left_q <= 8'd0;
            coeff_cnt_q  <= 9'd0;
            buf_q        <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            coeffs_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q      <= ST_RUN;
                        eta3_q       <= (i_eta == 2'd3);
                        bytes_left_q <= (i_eta == 2'd3) ? 8'd192 : 8'd128;
                        coeff_cnt_q  <= 9'd0;
                        buf_q        <= '0;
                        cnt_q        <= '0;
                    end
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
                ST_RUN: begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_d;
                    if (accept_s) begin
                        bytes_left_q <= bytes_left_q - 8'(IN_BYTES);
                    end
                    if (form_s) begin
                        coeff_cnt_q <= coeff_cnt_q + 9'(OUT_N);
                        valid_q     <= 1'b1;
                        coeffs_q    <= coeffs_d;
                        last_q      <= last_s;
                    end else if (drain_s) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                    // Last beat leaves the output register: polynomial done.
                    if (drain_s && last_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = ready_s;
    assign o_busy   = run_s;
    assign o_valid  = valid_q;
    assign o_last   = last_q;
    assign o_coeffs = coeffs_q;

endmodule

// File: tb/tb_cbd_stream.sv
// -----------------------------------------------------------------------------
// tb_cbd_stream
// Self-checking bench for cbd_stream (IN_BYTES=8, OUT_N=4). Expected
// coefficients come from a bit-level model of the CBD rule applied to the
// byte stream the bench sends.
// -----------------------------------------------------------------------------
module tb_cbd_stream;

    localparam int IN_BYTES = 8;
    localparam int OUT_N    = 4;

    logic                   clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic                   i_start = 1'b0;
    logic [1:0]             i_eta = 2'd0;
    logic [IN_BYTES*8-1:0]  i_data = '0;
    logic                   i_valid = 1'b0;
    logic                   o_ready;
    logic [OUT_N*12-1:0]    o_coeffs;
    logic                   o_valid;
    logic                   i_ready = 1'b0;
    logic                   o_last;
    logic                   o_busy;

    cbd_stream #(.IN_BYTES(IN_BYTES), .OUT_N(OUT_N)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_eta   (i_eta),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_coeffs(o_coeffs),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] stream [0:255];
    int         exp_c  [0:255];
    int         got_q  [$];
    int n_in, n_out, last_cnt, last_beat, stall_err, busy_after, timed_out, finished;

    // Reference: coefficient j = popcount(first eta bits) - popcount(next eta
    // bits) of the 2*eta-bit slice at stream bit 2*eta*j, lifted into 0..3328.
    function automatic void model(input int eta);
        for (int j = 0; j < 256; j++) begin
            int a = 0;
            int b = 0;
            for (int k = 0; k < eta; k++) begin
                int pa = 2*eta*j + k;
                int pb = 2*eta*j + eta + k;
                a += int'(stream[pa/8][pa%8]);
                b += int'(stream[pb/8][pb%8]);
            end
            exp_c[j] = (a - b < 0) ? (a - b + 3329) : (a - b);
        end
    endfunction

    function automatic logic [IN_BYTES*8-1:0] beat(input int idx);
        logic [IN_BYTES*8-1:0] d;
        for (int b = 0; b < IN_BYTES; b++) d[8*b +: 8] = stream[(idx*IN_BYTES + b) & 255];
        return d;
    endfunction

    // Drives one polynomial and records what comes out; checks are in callers.
    task automatic run_poly(input int eta, input int gaps, input int stop_after, input int pulse_at);
        logic                stalled = 1'b0;
        logic                done_now;
        logic [OUT_N*12-1:0] held_c = '0;
        logic                held_l = 1'b0;
        n_in = 0; n_out = 0; last_cnt = 0; last_beat = 0; stall_err = 0;
        busy_after = 1; timed_out = 0; finished = 0;
        got_q.delete();
        @(negedge clk);
        i_start = 1'b1;
        i_eta   = (eta == 3) ? 2'd3 : 2'($urandom_range(0, 2));
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (stalled) begin
                if (!o_valid || o_coeffs !== held_c || o_last !== held_l) stall_err++;
            end
            i_start = (cyc == pulse_at);
            if (cyc == pulse_at) i_eta = (eta == 3) ? 2'd2 : 2'd3;
            i_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_data  = beat(n_in);
            i_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (i_valid && o_ready) n_in++;
            done_now = o_valid && i_ready && o_last;
            if (o_valid && i_ready) begin
                for (int m = 0; m < OUT_N; m++) got_q.push_back(int'(o_coeffs[12*m +: 12]));
                n_out++;
                if (o_last) begin
                    last_cnt++;
                    last_beat = n_out;
                end
            end
            stalled = o_valid && !i_ready;
            held_c  = o_coeffs;
            held_l  = o_last;
            if (stop_after > 0 && n_out == stop_after) begin
                finished = 1;
                break;
            end
            @(negedge clk);
            if (done_now) begin
                busy_after = int'(o_busy);
                finished = 1;
                break;
            end
        end
        i_start = 1'b0;
        if (stop_after == 0) begin
            i_valid = 1'b0;
            i_ready = 1'b0;
        end
        if (!finished) timed_out = 1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", o_ready); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", o_last); end
        checks++; if (o_coeffs !== '0) begin errors++; $display("FAIL reset_coeffs: got %h expected 0", o_coeffs); end
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_eta2_zero();
        for (int i = 0; i < 256; i++) stream[i] = 8'h00;
        model(2);
        run_poly(2, 0, 0, -1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL zero_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_in != 16) begin errors++; $display("FAIL zero_in_beats: got %0d expected 16", n_in); end
        checks++; if (n_out != 64) begin errors++; $display("FAIL zero_out_beats: got %0d expected 64", n_out); end
        checks++; if (last_cnt != 1 || last_beat != 64) begin errors++; $display("FAIL zero_last: got count %0d at beat %0d expected 1 at 64", last_cnt, last_beat); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL zero_busy_after: got %0d expected 0", busy_after); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            checks++; if (got_q[j] != 0) begin errors++; if (errors < 20) $display("FAIL zero_coeff[%0d]: got %0d expected 0", j, got_q[j]); end
        end
    endtask

    task automatic test_eta2_pattern(input logic [7:0] pat, input int c_even);
        for (int i = 0; i < 256; i++) stream[i] = pat;
        model(2);
        run_poly(2, 0, 0, -1);
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL pat%h_count: got %0d expected 256", pat, got_q.size()); end
        checks++; if (got_q.size() > 1 && (got_q[0] != c_even || got_q[1] != 0)) begin errors++; $display("FAIL pat%h_first: got %0d,%0d expected %0d,0", pat, got_q[0], got_q[1], c_even); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            checks++; if (got_q[j] != exp_c[j]) begin errors++; if (errors < 20) $display("FAIL pat%h_coeff[%0d]: got %0d expected %0d", pat, j, got_q[j], exp_c[j]); end
        end
    endtask

    task automatic test_eta3_pattern();
        for (int i = 0; i < 256; i++) stream[i] = (i % 3 == 0) ? 8'h07 : 8'h00;
        model(3);
        run_poly(3, 0, 0, -1);
        checks++; if (n_in != 24) begin errors++; $display("FAIL eta3_in_beats: got %0d expected 24", n_in); end
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL eta3_count: got %0d expected 256", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            checks++; if (got_q[j] != ((j % 4 == 0) ? 3 : 0)) begin errors++; if (errors < 20) $display("FAIL eta3_coeff[%0d]: got %0d expected %0d", j, got_q[j], (j % 4 == 0) ? 3 : 0); end
        end
    endtask

    task automatic test_gaps(input int eta, input int rand_data);
        for (int i = 0; i < 256; i++) stream[i] = rand_data ? 8'($urandom_range(0, 255)) : 8'hFF;
        model(eta);
        run_poly(eta, 1, 0, -1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL gaps_timeout: got %0d expected 0", timed_out); end
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL gaps_count: got %0d expected 256", got_q.size()); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL gaps_stall_stable: got %0d changes expected 0", stall_err); end
        checks++; if (n_in != 16 * eta / 2 * 2 / 2 * (eta == 3 ? 1 : 1) && n_in != (eta == 3 ? 24 : 16)) begin errors++; $display("FAIL gaps_in_beats: got %0d", n_in); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            checks++; if (got_q[j] != exp_c[j]) begin errors++; if (errors < 20) $display("FAIL gaps_coeff[%0d]: got %0d expected %0d", j, got_q[j], exp_c[j]); end
        end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 256; i++) stream[i] = 8'($urandom_range(0, 255));
        run_poly(2, 0, 10, -1);
        checks++; if (n_out != 10) begin errors++; $display("FAIL rst_mid_beats: got %0d expected 10", n_out); end
        i_rst = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", o_busy); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %0b expected 0", o_ready); end
        i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        for (int i = 0; i < 256; i++) stream[i] = 8'h00;
        run_poly(2, 0, 0, 5);
        checks++; if (n_out != 64 || got_q.size() != 256) begin errors++; $display("FAIL rst_rerun_beats: got %0d beats expected 64", n_out); end
        checks++; if (last_beat != 64) begin errors++; $display("FAIL rst_rerun_last: got %0d expected 64", last_beat); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL rst_rerun_busy_after: got %0d expected 0", busy_after); end
        for (int j = 0; j < got_q.size() && j < 256; j++) begin
            checks++; if (got_q[j] != 0) begin errors++; if (errors < 20) $display("FAIL rst_rerun_coeff[%0d]: got %0d expected 0", j, got_q[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_eta2_zero();
        test_eta2_pattern(8'h0C, 3327);
        test_eta2_pattern(8'h03, 2);
        test_eta3_pattern();
        test_gaps(3, 0);
        test_gaps(2, 1);
        test_gaps(3, 1);
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
